// File: rtl/sum_result_collector.sv
// Consumer for the sum-to-N engine: captures each result with a one-cycle ack,
// queues it in a show-ahead FIFO, and keeps a running grand total and a result count.
module sum_result_collector #(
  parameter int DEPTH = 4,
  parameter int SUM_W = 5,
  parameter int TOT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sum_valid,
  input  logic [SUM_W-1:0]         sum,
  output logic                     ack,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [SUM_W-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [TOT_W-1:0]         total,
  output logic                     total_ovf,
  output logic [7:0]               n_results
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  state_t           r_state;
  logic             r_ack;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [LW-1:0]    r_level;
  logic [TOT_W-1:0] r_total;
  logic             r_total_ovf;
  logic [7:0]       r_n_results;
  logic [SUM_W-1:0] r_mem [DEPTH];

  logic             w_full;
  logic             w_rd_valid;
  logic             w_cap;
  logic             w_pop;
  logic [TOT_W:0]   w_total_sum;

  assign w_full      = (r_level == LW'(DEPTH));
  assign w_rd_valid  = (r_level != '0);
  assign w_cap       = (r_state == S_IDLE) && sum_valid && !w_full;
  assign w_pop       = rd_en && w_rd_valid;
  // Extra top bit catches the carry that makes total_ovf sticky.
  assign w_total_sum = {1'b0, r_total} + {{(TOT_W + 1 - SUM_W){1'b0}}, sum};

  // WAIT_LOW keeps a result that is still being presented from being taken twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cap) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
          end
        end
        S_ACK:      r_state <= S_WAIT_LOW;
        S_WAIT_LOW: if (!sum_valid) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_cap) r_tail <= r_tail + AW'(1);
      if (w_pop) r_head <= r_head + AW'(1);
      case ({w_cap, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: entries beyond the level count are never shown.
  always_ff @(posedge clk) begin
    if (w_cap) r_mem[r_tail] <= sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total     <= '0;
      r_total_ovf <= 1'b0;
      r_n_results <= '0;
    end else if (w_cap) begin
      r_total     <= w_total_sum[TOT_W-1:0];
      r_n_results <= r_n_results + 8'd1;
      if (w_total_sum[TOT_W]) r_total_ovf <= 1'b1;
    end
  end

  assign ack       = r_ack;
  assign rd_valid  = w_rd_valid;
  assign rd_data   = w_rd_valid ? r_mem[r_head] : '0;
  assign full      = w_full;
  assign level     = r_level;
  assign total     = r_total;
  assign total_ovf = r_total_ovf;
  assign n_results = r_n_results;

endmodule

// File: tb/tb_sum_result_collector.sv
// Directed bench for sum_result_collector: handshake, FIFO order and back-pressure,
// same-edge capture/pop, total wrap and asynchronous reset.
module tb_sum_result_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sum_valid = 1'b0;
  logic [4:0] sum = '0;
  logic       ack;
  logic       rd_en = 1'b0;
  logic       rd_valid;
  logic [4:0] rd_data;
  logic       full;
  logic [2:0] level;
  logic [7:0] total;
  logic       total_ovf;
  logic [7:0] n_results;

  int checks = 0;
  int errors = 0;

  sum_result_collector #(.DEPTH(4), .SUM_W(5), .TOT_W(8)) dut (
    .clk(clk), .reset(reset), .sum_valid(sum_valid), .sum(sum), .ack(ack),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .full(full),
    .level(level), .total(total), .total_ovf(total_ovf), .n_results(n_results)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one result for a single cycle and walks the handshake back to IDLE.
  task automatic do_capture(input logic [4:0] val);
    sum = val;
    sum_valid = 1'b1;
    tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL capture_ack(%0d): got %0d expected 1", val, ack); end
    sum_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++; if ({ack, rd_valid, rd_data, full, level, total, total_ovf, n_results} !== '0) begin errors++;
      $display("[TB] FAIL reset_outputs: got ack=%0d rdv=%0d rdd=%0d full=%0d lvl=%0d tot=%0d ovf=%0d n=%0d expected all 0",
               ack, rd_valid, rd_data, full, level, total, total_ovf, n_results); end
    #10 reset = 1'b0;
  endtask

  task automatic test_single();
    int acks;
    acks = 0;
    tick();
    sum = 5'd15;
    sum_valid = 1'b1;
    tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL single_ack: got %0d expected 1", ack); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
    checks++; if (rd_data !== 5'd15) begin errors++; $display("[TB] FAIL single_rd_data: got %0d expected 15", rd_data); end
    checks++; if (total !== 8'd15) begin errors++; $display("[TB] FAIL single_total: got %0d expected 15", total); end
    checks++; if (n_results !== 8'd1) begin errors++; $display("[TB] FAIL single_n: got %0d expected 1", n_results); end
    tick();
    if (ack === 1'b1) acks++;
    sum_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("[TB] FAIL single_extra_ack: got %0d extra pulses expected 0", acks); end
    checks++; if (n_results !== 8'd1) begin errors++; $display("[TB] FAIL single_no_recapture: got n=%0d expected 1", n_results); end
    pop_one();
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL single_drain_level: got %0d expected 0", level); end
  endtask

  task automatic test_fill();
    logic [4:0] vals [4];
    vals = '{5'd1, 5'd3, 5'd6, 5'd10};
    for (int i = 0; i < 4; i++) do_capture(vals[i]);
    checks++; if (full !== 1'b1 || level !== 3'd4) begin errors++; $display("[TB] FAIL fill_full: got full=%0d level=%0d expected full=1 level=4", full, level); end
    checks++; if (rd_data !== 5'd1) begin errors++; $display("[TB] FAIL fill_head: got %0d expected 1", rd_data); end
    sum = 5'd15;
    sum_valid = 1'b1;
    tick();
    tick();
    checks++; if (ack !== 1'b0 || level !== 3'd4) begin errors++; $display("[TB] FAIL fill_backpressure: got ack=%0d level=%0d expected ack=0 level=4", ack, level); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_data !== 5'd3) begin errors++; $display("[TB] FAIL fill_pop_head: got %0d expected 3", rd_data); end
    checks++; if (ack !== 1'b0 || level !== 3'd3 || full !== 1'b0) begin errors++; $display("[TB] FAIL fill_pop_state: got ack=%0d level=%0d full=%0d expected 0/3/0", ack, level, full); end
    tick();
    checks++; if (ack !== 1'b1 || level !== 3'd4) begin errors++; $display("[TB] FAIL fill_late_capture: got ack=%0d level=%0d expected ack=1 level=4", ack, level); end
    sum_valid = 1'b0;
    tick();
    tick();
    checks++; if (total !== 8'd50 || n_results !== 8'd6) begin errors++; $display("[TB] FAIL fill_totals: got total=%0d n=%0d expected 50/6", total, n_results); end
  endtask

  task automatic test_drain();
    logic [4:0] exp [4];
    exp = '{5'd3, 5'd6, 5'd10, 5'd15};
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp[i]) begin errors++; $display("[TB] FAIL drain_order[%0d]: got %0d expected %0d", i, rd_data, exp[i]); end
      pop_one();
    end
    checks++; if (level !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 5'd0) begin errors++; $display("[TB] FAIL drain_empty: got level=%0d rdv=%0d rdd=%0d expected 0/0/0", level, rd_valid, rd_data); end
    pop_one();
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL empty_read_level: got %0d expected 0", level); end
    do_capture(5'd7);
    checks++; if (rd_data !== 5'd7 || level !== 3'd1) begin errors++; $display("[TB] FAIL empty_read_ptrs: got rdd=%0d level=%0d expected 7/1", rd_data, level); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    do_capture(5'd2);
    do_capture(5'd4);
    checks++; if (level !== 3'd2 || rd_data !== 5'd2) begin errors++; $display("[TB] FAIL b2b_setup: got level=%0d rdd=%0d expected 2/2", level, rd_data); end
    sum = 5'd5;
    sum_valid = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    sum_valid = 1'b0;
    checks++; if (level !== 3'd2) begin errors++; $display("[TB] FAIL b2b_level: got %0d expected 2", level); end
    checks++; if (rd_data !== 5'd4 || ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_head: got rdd=%0d ack=%0d expected 4/1", rd_data, ack); end
    tick();
    tick();
    pop_one();
    checks++; if (rd_data !== 5'd5) begin errors++; $display("[TB] FAIL b2b_tail: got %0d expected 5", rd_data); end
    pop_one();
    checks++; if (total !== 8'd68 || n_results !== 8'd10) begin errors++; $display("[TB] FAIL b2b_totals: got total=%0d n=%0d expected 68/10", total, n_results); end
  endtask

  task automatic test_wrap();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_capture(5'd31);
      pop_one();
    end
    checks++; if (total !== 8'd248 || total_ovf !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pre: got total=%0d ovf=%0d expected 248/0", total, total_ovf); end
    do_capture(5'd31);
    pop_one();
    checks++; if (total !== 8'd23 || total_ovf !== 1'b1 || n_results !== 8'd9) begin errors++; $display("[TB] FAIL wrap: got total=%0d ovf=%0d n=%0d expected 23/1/9", total, total_ovf, n_results); end
    do_capture(5'd1);
    pop_one();
    checks++; if (total !== 8'd24 || total_ovf !== 1'b1) begin errors++; $display("[TB] FAIL wrap_sticky: got total=%0d ovf=%0d expected 24/1", total, total_ovf); end
  endtask

  task automatic test_reset_mid();
    sum = 5'd9;
    sum_valid = 1'b1;
    tick();
    checks++; if (ack !== 1'b1 || level !== 3'd1) begin errors++; $display("[TB] FAIL mid_capture: got ack=%0d level=%0d expected 1/1", ack, level); end
    #3 reset = 1'b1;
    #1;
    checks++; if ({ack, rd_valid, rd_data, full, level, total, total_ovf, n_results} !== '0) begin errors++;
      $display("[TB] FAIL mid_reset_outputs: got ack=%0d rdv=%0d rdd=%0d full=%0d lvl=%0d tot=%0d ovf=%0d n=%0d expected all 0",
               ack, rd_valid, rd_data, full, level, total, total_ovf, n_results); end
    #2 reset = 1'b0;
    tick();
    checks++; if (ack !== 1'b1 || level !== 3'd1 || total !== 8'd9 || n_results !== 8'd1) begin errors++;
      $display("[TB] FAIL post_reset_capture: got ack=%0d level=%0d total=%0d n=%0d expected 1/1/9/1", ack, level, total, n_results); end
    sum_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
